// File: rtl/seed_round_ctrl.sv
// seed_round_ctrl
//   Feistel round sequencer for the SEED datapath. Holds the 128-bit state
//   {L,R}, presents R to the round half-register and F function, folds the F
//   result into L on each committed round, and hands the final 128-bit block
//   to a consumer over a valid/ready handshake.
//
// Optional feature macro: SEED_ABORT_EN (adds the abort input).
//
// Ports
//   clk         in   1    clock
//   reset_n     in   1    asynchronous active-low reset
//   start       in   1    load plaintext and begin (sampled in IDLE only)
//   plaintext   in   128  {L0,R0}, L0 = [127:64]
//   start_f     in   1    key schedule has produced all subkeys
//   clk_en      in   1    round-advance qualifier
//   f_valid     in   1    F result valid for the current round
//   f_out       in   64   F(R, K_round)
//   abort       in   1    (SEED_ABORT_EN only) drop the operation, back to IDLE
//   right_out   out  64   current R
//   Rounds      out  4    current round index
//   sync        out  1    round committed this cycle; half-registers capture
//   busy        out  1    high outside IDLE
//   ct_valid    out  1    ciphertext valid
//   ct_ready    in   1    consumer accepts ciphertext
//   ciphertext  out  128  final {L,R}
//   dbg_state   out  2    FSM state (0 IDLE, 1 WAIT_KEY, 2 ROUND, 3 DONE)
//
// Handshake: a ciphertext transfer happens on a rising clock edge where
// ct_valid and ct_ready are both high. Once raised, ct_valid and ciphertext
// hold unchanged until that transfer; ct_ready while ct_valid is low is ignored.
module seed_round_ctrl #(
  parameter int NROUNDS = 16,
  parameter int HALF_W  = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [2*HALF_W-1:0] plaintext,
  input  logic                start_f,
  input  logic                clk_en,
  input  logic                f_valid,
  input  logic [HALF_W-1:0]   f_out,
`ifdef SEED_ABORT_EN
  input  logic                abort,
`endif
  output logic [HALF_W-1:0]   right_out,
  output logic [3:0]          Rounds,
  output logic                sync,
  output logic                busy,
  output logic                ct_valid,
  input  logic                ct_ready,
  output logic [2*HALF_W-1:0] ciphertext,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_KEY = 2'd1,
    S_ROUND    = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [HALF_W-1:0]     r_l;
  logic [HALF_W-1:0]     r_r;
  logic [3:0]            r_rounds;
  logic [2*HALF_W-1:0]   r_ct;
  logic                  r_ct_valid;
  logic                  r_sync_q;

  logic                  w_abort;
  logic                  w_commit;
  logic                  w_last;
  logic                  w_hs;
  logic                  w_load;

`ifdef SEED_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // A round commits on a qualified cycle. r_sync_q blocks a commit in the
  // cycle right after another one, so sync can never be high twice in a row
  // even if clk_en is held high.
  assign w_commit = (r_state == S_ROUND) & f_valid & clk_en & start_f &
                    ~r_sync_q & ~w_abort;
  assign w_last   = (r_rounds == 4'(NROUNDS - 1));
  assign w_hs     = (r_state == S_DONE) & r_ct_valid & ct_ready & ~w_abort;
  assign w_load   = (r_state == S_IDLE) & start & ~w_abort;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     if (start)               w_state_nxt = S_WAIT_KEY;
        S_WAIT_KEY: if (start_f)             w_state_nxt = S_ROUND;
        // start_f dropping here only stalls; there is no path back to WAIT_KEY.
        S_ROUND:    if (w_commit && w_last)  w_state_nxt = S_DONE;
        S_DONE:     if (w_hs)                w_state_nxt = S_IDLE;
        default:                             w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_l        <= '0;
      r_r        <= '0;
      r_rounds   <= '0;
      r_ct       <= '0;
      r_ct_valid <= 1'b0;
      r_sync_q   <= 1'b0;
    end else begin
      r_sync_q <= w_commit;
      if (w_abort) begin
        r_l        <= '0;
        r_r        <= '0;
        r_rounds   <= '0;
        r_ct_valid <= 1'b0;
      end else begin
        if (w_load) begin
          r_l      <= plaintext[2*HALF_W-1:HALF_W];
          r_r      <= plaintext[HALF_W-1:0];
          r_rounds <= '0;
        end
        if (w_commit) begin
          if (!w_last) begin
            r_l      <= r_r;
            r_r      <= r_l ^ f_out;
            r_rounds <= r_rounds + 4'd1;
          end else begin
            // Final round leaves the halves unswapped.
            r_ct       <= {r_l ^ f_out, r_r};
            r_ct_valid <= 1'b1;
          end
        end
        if (w_hs) begin
          r_ct_valid <= 1'b0;
          r_rounds   <= '0;
        end
      end
    end
  end

  assign right_out  = r_r;
  assign Rounds     = r_rounds;
  assign sync       = w_commit;
  assign busy       = (r_state != S_IDLE);
  assign ct_valid   = r_ct_valid;
  assign ciphertext = r_ct;
  assign dbg_state  = r_state;

endmodule
